// File: rtl/output_drain_dma_if.sv
// Signal bundle shared by output_drain_dma, the accumulator DMA read port and the
// memory write stream. The drain engine uses the master modport.
interface output_drain_dma_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [31:0]       base_addr;
    logic              acc_ready;
    logic              acc_rd_en;
    logic [ADDR_W-1:0] acc_rd_addr;
    logic [63:0]       acc_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [31:0]       out_addr;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [31:0]       stall_cycles;

    modport master (
        input  start, base_addr, acc_ready, acc_rd_data, out_ready,
        output acc_rd_en, acc_rd_addr, out_valid, out_data, out_addr, out_last,
               busy, done, stall_cycles
    );

    modport slave (
        output start, base_addr, acc_ready, acc_rd_data, out_ready,
        input  acc_rd_en, acc_rd_addr, out_valid, out_data, out_addr, out_last,
               busy, done, stall_cycles
    );
endinterface

// File: rtl/output_drain_dma.sv
// Tile drain engine: reads NUM_WORDS accumulator words, absorbs the read latency in a
// credit-checked skid FIFO and streams address-tagged beats. OUTPUT_DRAIN_PERF_EN adds a stall counter.
module output_drain_dma #(
    parameter int NUM_WORDS  = 32,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output_drain_dma_if.master bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_RDY = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

    logic [1:0]        r_state;
    logic [31:0]       r_base;
    logic [ADDR_W-1:0] r_rd_idx;
    logic              r_done;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [ADDR_W-1:0] r_pipe_idx [RD_LAT];
    logic [63:0]       r_mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_mem_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_start_acc;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_valid;
    logic              w_head_last;
    logic [ADDR_W-1:0] w_head_idx;
    logic [CNT_W-1:0]  w_inflight;
    logic [CNT_W-1:0]  w_occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Byte address of a word; wraps modulo 2^32 by construction.
    function automatic logic [31:0] byte_addr(input logic [31:0] base, input logic [ADDR_W-1:0] idx);
        return base + 32'({idx, 3'b000});
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe_vld[i]);
        end
    end

    // Credit rule: a read is only issued if its data is guaranteed a FIFO slot on return.
    assign w_occupancy  = r_count + w_inflight;
    assign w_issue      = (r_state == S_DRAIN) && (w_occupancy < CNT_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_rd_idx == ADDR_W'(NUM_WORDS - 1));
    assign w_start_acc  = bus.start && (r_state == S_IDLE);
    assign w_push       = r_pipe_vld[RD_LAT-1];
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && bus.out_ready;
    assign w_head_idx   = r_mem_idx[r_rd_ptr];
    assign w_head_last  = (w_head_idx == ADDR_W'(NUM_WORDS - 1));

    // Control stage: FSM, read index and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rd_idx <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE:     if (bus.start) r_state <= S_WAIT_RDY;
                S_WAIT_RDY: if (bus.acc_ready) r_state <= S_DRAIN;
                S_DRAIN:    if (w_last_issue) r_state <= S_FLUSH;
                S_FLUSH: begin
                    if (w_pop && w_head_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default:    r_state <= S_IDLE;
            endcase
            if (w_start_acc) begin
                r_rd_idx <= '0;
            end else if (w_issue) begin
                r_rd_idx <= w_last_issue ? '0 : r_rd_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_acc) r_base <= bus.base_addr;
    end

    // Read-latency stage: issue tags travel with the accumulator's pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_idx[0] <= r_rd_idx;
        for (int i = 1; i < RD_LAT; i++) r_pipe_idx[i] <= r_pipe_idx[i-1];
    end

    // Skid FIFO stage: pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.acc_rd_data;
            r_mem_idx[r_wr_ptr]  <= r_pipe_idx[RD_LAT-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full && !w_pop));

    // Payload is forced to zero when no beat is presented so idle outputs read 0.
    assign bus.out_valid   = w_valid;
    assign bus.out_data    = w_valid ? r_mem_data[r_rd_ptr] : 64'd0;
    assign bus.out_addr    = w_valid ? byte_addr(r_base, w_head_idx) : 32'd0;
    assign bus.out_last    = w_valid && w_head_last;
    assign bus.acc_rd_en   = w_issue;
    assign bus.acc_rd_addr = r_rd_idx;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;

`ifdef OUTPUT_DRAIN_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_start_acc) begin
            r_stall_cycles <= '0;
        end else if (w_valid && !bus.out_ready) begin
            r_stall_cycles <= sat_inc(r_stall_cycles);
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_output_drain_dma.sv
// Scoreboard bench for output_drain_dma: a reference drain model fills an expected-beat
// queue on each accepted start; an independent monitor checks every presented beat.
module tb_output_drain_dma;
    localparam int NUM_WORDS  = 32;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] addr;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_drain_dma_if #(.ADDR_W(ADDR_W)) bus();

    output_drain_dma #(
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .RD_LAT    (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    beat_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cur_tag = 32'h0000_A5A5;
    int          ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accumulator read port: data appears two cycles after the strobe, junk otherwise.
    logic              a1_vld = 1'b0;
    logic [ADDR_W-1:0] a1_addr = '0;
    always @(posedge clk) begin
        a1_vld  <= bus.acc_rd_en;
        a1_addr <= bus.acc_rd_addr;
        bus.acc_rd_data <= a1_vld ? {cur_tag, 22'd0, a1_addr} : {$urandom, $urandom};
    end

    initial begin
        int cyc;
        cyc = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 3 == 0);
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Reference: a tile is NUM_WORDS beats of {tag, index} at base + 8*index.
    task automatic push_drain(input logic [31:0] base, input logic [31:0] tag);
        for (int i = 0; i < NUM_WORDS; i++) begin
            beat_t b;
            b.data = {tag, 32'(i)};
            b.addr = base + 32'(i) * 32'd8;
            b.last = (i == NUM_WORDS - 1);
            exp_q.push_back(b);
        end
    endtask

    // Called at posedge+1; leaves at posedge+1 of the following cycle.
    task automatic start_drain(input logic [31:0] base, input bit accept);
        logic [31:0] tag;
        tag = $urandom;
        if (accept) begin
            cur_tag = tag;
            push_drain(base, tag);
        end
        bus.base_addr = base;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.base_addr = $urandom;
    endtask

    task automatic wait_done(input string name, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
            seen = bus.done;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_beats(input int n);
        int cnt;
        int guard;
        cnt   = 0;
        guard = 0;
        while (cnt < n && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (bus.out_valid && bus.out_ready) cnt++;
        end
        check("beat_wait", 64'(cnt), 64'(n));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_data"}, bus.out_data, 64'd0);
        check({name, "_addr"}, 64'(bus.out_addr), 64'd0);
        check({name, "_last"}, 64'(bus.out_last), 64'd0);
        check({name, "_busy"}, 64'(bus.busy), 64'd0);
        check({name, "_done"}, 64'(bus.done), 64'd0);
        check({name, "_rd_en"}, 64'(bus.acc_rd_en), 64'd0);
        check({name, "_rd_addr"}, 64'(bus.acc_rd_addr), 64'd0);
        check({name, "_stall"}, 64'(bus.stall_cycles), 64'd0);
    endtask

    // Monitor: beat scoreboard, done timing, credit bound, read order, hold stability.
    initial begin
        int          outstanding;
        int          rd_exp;
        bit          done_exp;
        bit          hold_vld;
        bit          hs;
        beat_t       held;
        beat_t       cur;
        beat_t       e;
`ifdef OUTPUT_DRAIN_PERF_EN
        logic [31:0] tb_stall;
        tb_stall = '0;
`endif
        outstanding = 0;
        rd_exp      = 0;
        done_exp    = 1'b0;
        hold_vld    = 1'b0;
        held        = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                outstanding = 0;
                rd_exp      = 0;
                done_exp    = 1'b0;
                hold_vld    = 1'b0;
`ifdef OUTPUT_DRAIN_PERF_EN
                tb_stall    = '0;
`endif
            end else begin
                hs       = bus.out_valid && bus.out_ready;
                cur.data = bus.out_data;
                cur.addr = bus.out_addr;
                cur.last = bus.out_last;

                check("done_timing", 64'(bus.done), 64'(done_exp));
                if (bus.done) check("busy_at_done", 64'(bus.busy), 64'd0);
                done_exp = hs && bus.out_last;

`ifdef OUTPUT_DRAIN_PERF_EN
                check("stall_cycles", 64'(bus.stall_cycles), 64'(tb_stall));
                if (bus.start && !bus.busy) tb_stall = '0;
                else if (bus.out_valid && !bus.out_ready) tb_stall = tb_stall + 32'd1;
`else
                check("stall_cycles", 64'(bus.stall_cycles), 64'd0);
`endif

                check("credit_bound", 64'(outstanding <= FIFO_DEPTH), 64'd1);
                if (outstanding >= FIFO_DEPTH) check("issue_stop", 64'(bus.acc_rd_en), 64'd0);
                if (bus.acc_rd_en) begin
                    check("rd_addr", 64'(bus.acc_rd_addr), 64'(rd_exp));
                    rd_exp = (rd_exp + 1) % NUM_WORDS;
                end
                outstanding = outstanding + int'(bus.acc_rd_en) - int'(hs);

                if (hold_vld) begin
                    check("hold_valid", 64'(bus.out_valid), 64'd1);
                    check("hold_data", cur.data, held.data);
                    check("hold_addr", 64'(cur.addr), 64'(held.addr));
                    check("hold_last", 64'(cur.last), 64'(held.last));
                end
                hold_vld = bus.out_valid && !bus.out_ready;
                held     = cur;

                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", cur.data, e.data);
                        check("beat_addr", 64'(cur.addr), 64'(e.addr));
                        check("beat_last", 64'(cur.last), 64'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        bus.start     = 1'b0;
        bus.base_addr = 32'd0;
        bus.acc_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic drain with exact latency and back-to-back beats
        ready_mode    = 0;
        bus.acc_ready = 1'b1;
        start_drain(32'h1000_0000, 1'b1);
        @(negedge clk); check("t1_rd_en_s1", 64'(bus.acc_rd_en), 64'd0);
        check("t1_busy", 64'(bus.busy), 64'd1);
        @(negedge clk); check("t1_rd_en_s2", 64'(bus.acc_rd_en), 64'd1);
        @(negedge clk); check("t1_valid_s3", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("t1_valid_s4", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("t1_valid_s5", 64'(bus.out_valid), 64'd1);
        wait_done("t1", cycles);
        check("t1_done_cycle", 64'(cycles), 64'd32);
        @(posedge clk); #1;

        // Backpressure: ready one cycle in three
        ready_mode = 1;
        start_drain($urandom, 1'b1);
        wait_done("t2", cycles);
        @(posedge clk); #1;

        // Late acc_ready; accumulator drops it after the first read
        ready_mode    = 0;
        bus.acc_ready = 1'b0;
        start_drain($urandom, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_no_rd", 64'(bus.acc_rd_en), 64'd0);
            check("t3_busy", 64'(bus.busy), 64'd1);
        end
        @(posedge clk); #1;
        bus.acc_ready = 1'b1;
        @(negedge clk); check("t3_rd_same_cycle", 64'(bus.acc_rd_en), 64'd0);
        @(negedge clk); check("t3_rd_next_cycle", 64'(bus.acc_rd_en), 64'd1);
        @(posedge clk); #1;
        bus.acc_ready = 1'b0;
        wait_done("t3", cycles);
        bus.acc_ready = 1'b1;
        @(posedge clk); #1;

        // Start while busy is dropped; start on the done cycle is accepted
        start_drain(32'h2000_0100, 1'b1);
        wait_beats(5);
        @(posedge clk); #1;
        start_drain(32'h3333_0000, 1'b0);
        wait_done("t4a", cycles);
        start_drain(32'h4000_0040, 1'b1);
        wait_done("t4b", cycles);
        @(posedge clk); #1;

        // Reset mid-drain, then a clean drain from word 0
        start_drain($urandom, 1'b1);
        wait_beats(13);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_reset");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_drain(32'h0000_8000, 1'b1);
        wait_done("t5", cycles);
        @(posedge clk); #1;

        // Address wrap past 2^32
        start_drain(32'hFFFF_FFF0, 1'b1);
        wait_done("t6", cycles);
        @(posedge clk); #1;

        // Randomized drains: random base, ready pattern and acc_ready delay
        ready_mode = 2;
        for (int n = 0; n < 4; n++) begin
            int dly;
            dly = $urandom_range(0, 6);
            bus.acc_ready = 1'b0;
            start_drain($urandom, 1'b1);
            repeat (dly) begin
                @(posedge clk); #1;
            end
            bus.acc_ready = 1'b1;
            wait_done("rnd", cycles);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
